// File: rtl/video_mixer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_mixer_pkg
//  Description : Shared widths, field positions, pipeline depth and the
//                pending-write state encoding for the video mixer.
//  Revision    : 1.0  initial release
// ============================================================================
package video_mixer_pkg;

    // Palette address / data widths
    localparam int PAL_AW  = 8;
    localparam int PAL_DW  = 8;

    // SPCOL field positions: {BH, PN[4:0], PIX[1:0]}
    localparam int BH_BIT  = 7;
    localparam int PIX_LSB = 0;

    // Palette data / RGB field positions: {B[1:0], G[2:0], R[2:0]}
    localparam int R_LSB   = 0;
    localparam int R_MSB   = 2;
    localparam int G_LSB   = 3;
    localparam int G_MSB   = 5;
    localparam int B_LSB   = 6;
    localparam int B_MSB   = 7;

    // Input-to-RGB latency in VCLK cycles
    localparam int MIX_LAT = 3;

    // Pending CPU-write buffer state
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } pend_state_t;

endpackage
`default_nettype wire

// File: rtl/video_mixer_pal_ram.sv
`default_nettype none
// ============================================================================
//  Module      : video_mixer_pal_ram
//  Description : Palette RAM, simple dual port, synchronous read. A read and
//                a write to the same address in one cycle return the old
//                contents; no reset on the array.
//  Revision    : 1.0  initial release
// ============================================================================
module video_mixer_pal_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    // Write port plus registered read; the read samples pre-write contents
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/video_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : video_mixer
//  Description : Sprite/playfield priority, 256x8 palette lookup and
//                registered RGB output with blanking. CPU palette writes are
//                held in a one-entry buffer and committed during blank.
//                Optional macro MIX_LAYER_MASK_EN adds a LAYER_MASK input.
//  Revision    : 1.0  initial release
// ============================================================================
module video_mixer
    import video_mixer_pkg::*;
#(
    parameter bit         DEFER_WRITES = 1'b1,
    parameter logic [7:0] PAL_INIT     = 8'h00
) (
    input  logic              VCLK,
    input  logic              RST_N,
    input  logic [7:0]        SPCOL,
    input  logic [7:0]        PFCOL,
    input  logic              BLANK,
`ifdef MIX_LAYER_MASK_EN
    input  logic [1:0]        LAYER_MASK,
`endif
    input  logic              PALWE,
    input  logic [PAL_AW-1:0] PALAD,
    input  logic [PAL_DW-1:0] PALDT,
    output logic              PALBUSY,
    output logic [2:0]        R,
    output logic [2:0]        G,
    output logic [1:0]        B,
    output logic              OBLANK
);

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    logic [7:0]         r_sp_s0;
    logic [7:0]         r_pf_s0;
    logic [MIX_LAT-2:0] r_blank_dly;
    logic [1:0]         r_mask_s0;
    logic               w_spr_on;
    logic               w_pf_on;
    logic               w_pf_masked;
    logic [PAL_AW-1:0]  w_idx;
    logic [PAL_DW-1:0]  w_ram_rd;
    pend_state_t        r_state;
    pend_state_t        w_state_nxt;
    logic               w_commit;
    logic               w_latch;
    logic [PAL_AW-1:0]  r_wa;
    logic [PAL_DW-1:0]  r_wd;
    logic               w_unused_pf7;

    // Asserts asynchronously, releases two VCLK edges after RST_N rises
    always_ff @(posedge VCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    // S0: capture pixel inputs; blank is delayed to line up with RAM data
    always_ff @(posedge VCLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sp_s0     <= '0;
            r_pf_s0     <= '0;
            r_blank_dly <= '0;
            r_mask_s0   <= '0;
        end else begin
            r_sp_s0     <= SPCOL;
            r_pf_s0     <= PFCOL;
            r_blank_dly <= {r_blank_dly[MIX_LAT-3:0], BLANK};
`ifdef MIX_LAYER_MASK_EN
            r_mask_s0   <= LAYER_MASK;
`else
            r_mask_s0   <= 2'b00;
`endif
        end
    end

    // Bit 7 of the playfield pixel never reaches the palette index
    assign w_unused_pf7 = r_pf_s0[7];

    // S1: sprite wins unless it is behind-priority over a visible playfield
    always_comb begin
        w_spr_on    = (r_sp_s0[PIX_LSB+1:PIX_LSB] != 2'b00) && !r_mask_s0[0];
        w_pf_on     = (r_pf_s0[1:0] != 2'b00) && !r_mask_s0[1];
        w_pf_masked = r_mask_s0[1];
        if (w_spr_on && !(r_sp_s0[BH_BIT] && w_pf_on)) begin
            w_idx = {1'b1, r_sp_s0[6:0]};
        end else if (w_pf_masked) begin
            w_idx = 8'h00;
        end else begin
            w_idx = {1'b0, r_pf_s0[6:0]};
        end
    end

    // S2: palette read; commits come from the pending buffer
    video_mixer_pal_ram #(
        .AW (PAL_AW),
        .DW (PAL_DW)
    ) u_pal_ram (
        .clk     (VCLK),
        .i_we    (w_commit),
        .i_waddr (r_wa),
        .i_wdata (r_wd),
        .i_raddr (w_idx),
        .o_rdata (w_ram_rd)
    );

    // S3: output registers, forced black during blank
    always_ff @(posedge VCLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            R      <= PAL_INIT[R_MSB:R_LSB];
            G      <= PAL_INIT[G_MSB:G_LSB];
            B      <= PAL_INIT[B_MSB:B_LSB];
            OBLANK <= 1'b1;
        end else begin
            OBLANK <= r_blank_dly[MIX_LAT-2];
            if (r_blank_dly[MIX_LAT-2]) begin
                R <= 3'b000;
                G <= 3'b000;
                B <= 2'b00;
            end else begin
                R <= w_ram_rd[R_MSB:R_LSB];
                G <= w_ram_rd[G_MSB:G_LSB];
                B <= w_ram_rd[B_MSB:B_LSB];
            end
        end
    end

    // Pending-buffer state and latched address/data
    always_ff @(posedge VCLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
            r_wa    <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_wa <= PALAD;
                r_wd <= PALDT;
            end
        end
    end

    // Next state: a strobe coinciding with a commit keeps the buffer full
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (PALWE) begin
                    w_latch     = 1'b1;
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                w_commit = DEFER_WRITES ? BLANK : 1'b1;
                if (PALWE) begin
                    w_latch = 1'b1;
                end else if (w_commit) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign PALBUSY = (r_state == PEND);

endmodule
`default_nettype wire
